xadc_drp_responder: RTL and testbench

XADC_DRP_RESPONDER -- requirements
Module: xadc_drp_responder

---
 rtl/xadc_drp_responder_pkg.sv | 25 ++
 rtl/xadc_conv_seq.sv | 69 ++++++
 rtl/xadc_drp_responder.sv | 141 ++++++++++++++
 tb/tb_xadc_drp_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_drp_responder_pkg.sv
// Shared channel codes, DRP register map and DRP FSM state encoding for the
// XADC-style DRP responder.
package xadc_drp_responder_pkg;

    localparam logic [4:0] CH_AUX3  = 5'h13;
    localparam logic [4:0] CH_AUX11 = 5'h1B;

    localparam logic [6:0] ADDR_AUX3  = 7'h13;
    localparam logic [6:0] ADDR_AUX11 = 7'h1B;
    localparam logic [6:0] ADDR_CFG0  = 7'h40;
    localparam logic [6:0] ADDR_CFG1  = 7'h41;
    localparam logic [6:0] ADDR_CFG2  = 7'h42;

    typedef enum logic [1:0] {
        DRP_IDLE = 2'd0,
        DRP_WAIT = 2'd1,
        DRP_ACK  = 2'd2
    } drp_state_e;

    // sel=0 converts aux3, sel=1 converts aux11
    function automatic logic [4:0] chan_code(input logic sel);
        return sel ? CH_AUX11 : CH_AUX3;
    endfunction

endpackage

// File: rtl/xadc_conv_seq.sv
// Conversion timer/sequencer: CONV_CYCLES busy cycles, then a one-cycle eoc,
// alternating aux3/aux11 starting with aux3 after reset.
module xadc_conv_seq
    import xadc_drp_responder_pkg::*;
#(
    parameter int CONV_CYCLES = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       busy_o,
    output logic       eoc_o,
    output logic [4:0] channel_o,
    output logic       sel_o
);

    localparam logic [9:0] LAST = 10'(CONV_CYCLES - 1);

    logic       busy_q, busy_d;
    logic       eoc_q, eoc_d;
    logic       sel_q, sel_d;
    logic [9:0] cnt_q, cnt_d;
    logic [4:0] chan_q, chan_d;

    always_comb begin
        busy_d = busy_q;
        eoc_d  = 1'b0;
        sel_d  = sel_q;
        cnt_d  = cnt_q;
        chan_d = chan_q;
        if (busy_q) begin
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                eoc_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 10'd1;
            end
        end else begin
            // Either just out of reset or leaving the eoc cycle: start next conversion
            busy_d = 1'b1;
            cnt_d  = '0;
            if (eoc_q) begin
                sel_d  = ~sel_q;
                chan_d = chan_code(sel_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            eoc_q  <= 1'b0;
            sel_q  <= 1'b0;
            cnt_q  <= '0;
            chan_q <= '0;
        end else begin
            busy_q <= busy_d;
            eoc_q  <= eoc_d;
            sel_q  <= sel_d;
            cnt_q  <= cnt_d;
            chan_q <= chan_d;
        end
    end

    assign busy_o    = busy_q;
    assign eoc_o     = eoc_q;
    assign channel_o = chan_q;
    assign sel_o     = sel_q;

endmodule

// File: rtl/xadc_drp_responder.sv
// DRP slave with fixed READ_LAT response, two result registers fed by the
// conversion sequencer and three R/W config registers.
// Optional macro XADC_DRP_RAMP_EN replaces the sample inputs with an internal ramp.
module xadc_drp_responder
    import xadc_drp_responder_pkg::*;
#(
    parameter int          CONV_CYCLES = 26,
    parameter int          READ_LAT    = 2,
    parameter logic [11:0] RAMP_STEP   = 12'd37
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [6:0]  daddr_in,
    input  logic [15:0] di_in,
    input  logic [11:0] sample_aux3,
    input  logic [11:0] sample_aux11,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic        eoc_out,
    output logic [4:0]  channel_out,
    output logic        busy_out,
    output logic        proto_err
);

    localparam logic [3:0] WAIT_LAST = 4'((READ_LAT > 1) ? READ_LAT - 2 : 0);

    logic        conv_sel;
    logic [11:0] sample;

    xadc_conv_seq #(.CONV_CYCLES(CONV_CYCLES)) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy_o   (busy_out),
        .eoc_o    (eoc_out),
        .channel_o(channel_out),
        .sel_o    (conv_sel)
    );

`ifdef XADC_DRP_RAMP_EN
    logic [11:0] ramp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ramp_q <= '0;
        else if (eoc_out) ramp_q <= ramp_q + RAMP_STEP;
    end

    assign sample = ramp_q;
`else
    assign sample = conv_sel ? sample_aux11 : sample_aux3;
`endif

    logic [15:0] res3_q, res11_q;
    logic [15:0] cfg0_q, cfg1_q, cfg2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res3_q  <= '0;
            res11_q <= '0;
        end else if (eoc_out) begin
            if (conv_sel) res11_q <= {sample, 4'h0};
            else          res3_q  <= {sample, 4'h0};
        end
    end

    logic [15:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (daddr_in)
            ADDR_AUX3:  rd_mux = res3_q;
            ADDR_AUX11: rd_mux = res11_q;
            ADDR_CFG0:  rd_mux = cfg0_q;
            ADDR_CFG1:  rd_mux = cfg1_q;
            ADDR_CFG2:  rd_mux = cfg2_q;
            default:    rd_mux = '0;
        endcase
    end

    drp_state_e  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        accept;
    logic [15:0] rdata_q;
    logic        perr_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        accept  = 1'b0;
        case (state_q)
            DRP_IDLE: begin
                if (den_in) begin
                    accept  = 1'b1;
                    wcnt_d  = '0;
                    state_d = (READ_LAT == 1) ? DRP_ACK : DRP_WAIT;
                end
            end
            DRP_WAIT: begin
                if (wcnt_q == WAIT_LAST) state_d = DRP_ACK;
                else                     wcnt_d  = wcnt_q + 4'd1;
            end
            DRP_ACK:  state_d = DRP_IDLE;
            default:  state_d = DRP_IDLE;
        endcase
    end

    // Read data and writes both resolve at acceptance, so later conversions
    // cannot disturb an in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DRP_IDLE;
            wcnt_q  <= '0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
            cfg0_q  <= '0;
            cfg1_q  <= '0;
            cfg2_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (den_in && state_q != DRP_IDLE) perr_q <= 1'b1;
            if (accept) begin
                rdata_q <= dwe_in ? 16'h0000 : rd_mux;
                if (dwe_in) begin
                    case (daddr_in)
                        ADDR_CFG0: cfg0_q <= di_in;
                        ADDR_CFG1: cfg1_q <= di_in;
                        ADDR_CFG2: cfg2_q <= di_in;
                        default:   ;
                    endcase
                end
            end
        end
    end

    assign drdy_out  = (state_q == DRP_ACK);
    assign do_out    = drdy_out ? rdata_q : 16'h0000;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Scoreboard bench: a cycle-count model predicts conversions and DRP replies;
// a negedge monitor pops expected read data whenever drdy_out is seen.
module tb_xadc_drp_responder;

    localparam int          CONV = 26;
    localparam int          RL   = 2;
    localparam logic [11:0] STEP = 12'd37;
    localparam int          PER  = CONV + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        den_in = 1'b0, dwe_in = 1'b0;
    logic [6:0]  daddr_in = '0;
    logic [15:0] di_in = '0;
    logic [11:0] sample_aux3 = '0, sample_aux11 = '0;
    logic [15:0] do_out;
    logic        drdy_out, eoc_out, busy_out, proto_err;
    logic [4:0]  channel_out;

    int checks = 0;
    int errors = 0;

    xadc_drp_responder #(.CONV_CYCLES(CONV), .READ_LAT(RL), .RAMP_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .den_in(den_in), .dwe_in(dwe_in),
        .daddr_in(daddr_in), .di_in(di_in), .sample_aux3(sample_aux3),
        .sample_aux11(sample_aux11), .do_out(do_out), .drdy_out(drdy_out),
        .eoc_out(eoc_out), .channel_out(channel_out), .busy_out(busy_out),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Reference model: m_n = rising edges since reset release
    int          m_n, m_pend, m_k;
    bit          m_perr;
    logic [15:0] m_res [2];
    logic [15:0] m_cfg [3];
    logic [4:0]  m_chan;
    logic [11:0] m_ramp, m_s;
    logic [15:0] expq [$];

    function automatic logic [15:0] m_read(input logic [6:0] a);
        case (a)
            7'h13:   return m_res[0];
            7'h1B:   return m_res[1];
            7'h40:   return m_cfg[0];
            7'h41:   return m_cfg[1];
            7'h42:   return m_cfg[2];
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_pend = 0; m_perr = 0; m_chan = 5'h00; m_ramp = 12'h000;
            m_res[0] = '0; m_res[1] = '0;
            m_cfg[0] = '0; m_cfg[1] = '0; m_cfg[2] = '0;
            expq.delete();
        end else begin
            if (m_pend > 0) begin
                if (den_in) m_perr = 1;
                m_pend--;
            end else if (den_in) begin
                expq.push_back(dwe_in ? 16'h0000 : m_read(daddr_in));
                if (dwe_in && daddr_in >= 7'h40 && daddr_in <= 7'h42)
                    m_cfg[daddr_in - 7'h40] = di_in;
                m_pend = RL;
            end
            if (m_n > 0 && m_n % PER == 0) begin
                m_k = m_n / PER - 1;
`ifdef XADC_DRP_RAMP_EN
                m_s = m_ramp;
                m_ramp = m_ramp + STEP;
`else
                m_s = (m_k % 2 == 1) ? sample_aux11 : sample_aux3;
`endif
                m_res[m_k % 2] = {m_s, 4'h0};
                m_chan = (m_k % 2 == 1) ? 5'h1B : 5'h13;
            end
            m_n++;
        end
    end

    // Monitor
    logic        exp_drdy, exp_eoc, exp_busy;
    logic [15:0] exp_do;
    always @(negedge clk) begin
        exp_drdy = (m_pend == 1);
        exp_eoc  = (m_n > 0) && (m_n % PER == 0);
        exp_busy = (m_n > 0) && (m_n % PER != 0);
        checks++;
        if (drdy_out !== exp_drdy) begin
            errors++;
            $display("FAIL drdy_timing t=%0t got %b want %b", $time, drdy_out, exp_drdy);
        end
        if (drdy_out) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL drdy_unexpected t=%0t do_out %h with empty scoreboard", $time, do_out);
            end else begin
                exp_do = expq.pop_front();
                if (do_out !== exp_do) begin
                    errors++;
                    $display("FAIL read_data t=%0t got %h want %h", $time, do_out, exp_do);
                end
            end
        end else begin
            checks++;
            if (do_out !== 16'h0000) begin
                errors++;
                $display("FAIL do_out_idle t=%0t got %h want 0000", $time, do_out);
            end
        end
        checks++;
        if ({eoc_out, busy_out, channel_out} !== {exp_eoc, exp_busy, m_chan}) begin
            errors++;
            $display("FAIL conv_state t=%0t got eoc=%b busy=%b ch=%h want eoc=%b busy=%b ch=%h",
                     $time, eoc_out, busy_out, channel_out, exp_eoc, exp_busy, m_chan);
        end
        checks++;
        if (proto_err !== m_perr) begin
            errors++;
            $display("FAIL proto_err t=%0t got %b want %b", $time, proto_err, m_perr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic drp(input logic we, input logic [6:0] a, input logic [15:0] d);
        den_in = 1'b1; dwe_in = we; daddr_in = a; di_in = d;
        tick();
        den_in = 1'b0; dwe_in = 1'b0;
        repeat (RL + 1) tick();
    endtask

    int first_eoc;
    int guard;
    logic [6:0] ra;

    initial begin
        sample_aux3 = 12'hABC; sample_aux11 = 12'h5A5;
        repeat (3) tick();
        check("reset_outputs", {16'(do_out), drdy_out, eoc_out, busy_out, proto_err, channel_out}, '0);
        rst_n = 1'b1;

        first_eoc = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (eoc_out) begin first_eoc = i; break; end
        end
        check("first_eoc_cycle", 32'(first_eoc), 32'd27);
        tick();
        check("first_channel", 32'(channel_out), 32'h13);

        drp(1'b0, 7'h13, 16'h0);           // aux3 result ABC0
        drp(1'b1, 7'h41, 16'h1234);
        drp(1'b0, 7'h41, 16'h0);
        drp(1'b1, 7'h13, 16'hFFFF);
        drp(1'b0, 7'h13, 16'h0);
        drp(1'b0, 7'h7F, 16'h0);
        guard = 0;
        while (m_n < 2 * PER + 2 && guard < 200) begin tick(); guard++; end
        drp(1'b0, 7'h1B, 16'h0);           // aux11 result

        // eoc of aux3 lands while a read of 7'h13 is in WAIT
        sample_aux3 = 12'h123;
        guard = 0;
        while (m_n % (2 * PER) != PER - 1 && guard < 200) begin tick(); guard++; end
        check("align_guard", 32'(guard < 200), 32'd1);
        drp(1'b0, 7'h13, 16'h0);
        drp(1'b0, 7'h13, 16'h0);

        // random traffic
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) sample_aux3  = 12'($urandom);
            if ($urandom_range(0, 3) == 0) sample_aux11 = 12'($urandom);
            case ($urandom_range(0, 6))
                0: ra = 7'h13;
                1: ra = 7'h1B;
                2: ra = 7'h40;
                3: ra = 7'h41;
                4: ra = 7'h42;
                5: ra = 7'h7F;
                default: ra = 7'($urandom);
            endcase
            drp(1'($urandom_range(0, 1)), ra, 16'($urandom));
            repeat ($urandom_range(0, 5)) tick();
        end

        // den during WAIT: ignored, proto_err sticky
        den_in = 1'b1; dwe_in = 1'b0; daddr_in = 7'h1B;
        tick();
        dwe_in = 1'b1; daddr_in = 7'h40; di_in = 16'hBEEF;
        tick();
        den_in = 1'b0; dwe_in = 1'b0;
        repeat (RL + 2) tick();
        check("proto_err_set", 32'(proto_err), 32'd1);
        drp(1'b0, 7'h40, 16'h0);
        check("proto_err_sticky", 32'(proto_err), 32'd1);

        // reset mid-WAIT aborts the transaction
        den_in = 1'b1; dwe_in = 1'b0; daddr_in = 7'h13;
        tick();
        den_in = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        check("abort_no_drdy", 32'(drdy_out), 32'd0);
        rst_n = 1'b1;
        tick();
        check("busy_after_release", 32'(busy_out), 32'd1);
        check("proto_err_cleared", 32'(proto_err), 32'd0);
        guard = 0;
        while (m_n < 3 * PER + 2 && guard < 200) begin tick(); guard++; end
        drp(1'b0, 7'h13, 16'h0);
        drp(1'b0, 7'h1B, 16'h0);
        drp(1'b0, 7'h41, 16'h0);

        repeat (10) tick();
        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
